ram_file_responder: RTL and testbench
=====================================

Name: ram_file_responder

Overview:
- Data-memory responder for the PIC16F core.
- Consumes the 9-bit file address produced by the file address mux and serves reads and writes to banked GPR RAM, the shared RAM region and the STATUS/FSR registers.
- Owns STATUS (RP1:RP0, IRP, flags) and FSR, and drives them back to the address mux, closing the banking/indirect loop.

Parameters:
- GPR_BANKS, 3, number of banks (1..4) implementing GPR offsets 0x20-0x6F; banks at or above GPR_BANKS read 0x00 in that range.
- STATUS_RESET, 8'h18, STATUS reset value (TO=PD=1, all others 0).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- file_addr  input  9  {bank[1:0], offset[6:0]} from the address mux.
- wr_en  input  1  write file_addr with wr_data on this edge.
- wr_data  input  8  write data.
- rd_en  input  1  request read of file_addr.
- rd_data  output  8  read data, valid when rd_valid.
- rd_valid  output  1  one-cycle pulse, read result present.
- alu_flag_we  input  1  ALU updates Z/DC/C this edge.
- alu_z, alu_dc, alu_c  input  1 each  ALU flag values.
- status  output  8  full STATUS register.
- status_rp  output  2  STATUS[6:5], to address mux.
- status_irp  output  1  STATUS[7], to address mux.
- fsr  output  8  FSR register, to address mux.

Behaviour:
- Reset (async, rst_n low): status=STATUS_RESET, fsr=0x00, rd_data=0x00, rd_valid=0; pending read discarded. GPR contents are not reset.
- Address decode on offset (file_addr[6:0]), any bank:
  - 0x00 INDF: reads 0x00, writes ignored. The mux has already resolved indirection, so reaching 0x00 means FSR/IRP pointed at INDF.
  - 0x03 STATUS and 0x04 FSR: mirrored in all 4 banks.
  - 0x70-0x7F shared RAM: 16 bytes, same cell for all 4 banks.
  - 0x20-0x6F GPR: 80 bytes per bank, for banks < GPR_BANKS.
  - All other offsets: read 0x00, writes ignored.
- Writes: take effect at the rising edge with wr_en=1. Visible on status/fsr outputs and to reads issued on the following cycle.
- STATUS write:
  - bits 7:5 take wr_data[7:5];
  - TO/PD (bits 4:3) are read-only and unchanged;
  - Z/DC/C take wr_data[2:0] unless alu_flag_we is high in the same cycle, in which case ALU values win.
  - IRP/RP are still written in that case.
- alu_flag_we alone: updates bits 2:0 only.
- Reads:
  - rd_en sampled at edge N; rd_data/rd_valid valid after edge N+1.
  - rd_valid high for exactly one cycle per request. Back-to-back rd_en gives back-to-back results, one per cycle.
- Read and write to the same address in the same cycle: read returns the pre-write value.
- rd_data holds its last value while rd_valid=0.
- Reset asserted mid-read: no rd_valid pulse for that request.

Test Plan:
- Reset: release rst_n -> status=0x18, fsr=0x00, status_rp=0, status_irp=0, rd_valid=0, rd_data=0x00.
- Bank separation: write 0x5A@0x020, 0x11@0x0A0 -> read 0x020 gives 0x5A one cycle later with a single rd_valid pulse; read 0x0A0 gives 0x11; read 0x1A0 (bank 3, GPR_BANKS=3) gives 0x00.
- Shared mirror: write 0x33@0x1F5 -> reads of 0x075, 0x0F5, 0x175 each return 0x33.
- STATUS:
  - write 0x60@0x083 -> status=0x78, status_rp=2'b11;
  - then write 0x07@0x003 with alu_flag_we=1, z=0, dc=0, c=1 -> status=0x19;
  - then alu_flag_we alone with z=1 -> status=0x1D.
- FSR/INDF: write 0x84@0x104 -> fsr=0x84, read 0x004 gives 0x84; write 0xAA@0x000 -> read 0x080 gives 0x00, no other cell changed.
- Hazards:
  - write 0x22 and read at 0x030 in the same cycle (old value 0x5A) -> rd_data=0x5A, next read gives 0x22;
  - assert rst_n low one cycle after rd_en -> no rd_valid pulse, rd_data=0x00.

Source files
------------

// File: rtl/ram_file_responder.sv
// rtl/ram_file_responder.sv - PIC16F data-memory responder: banked GPR, shared RAM, STATUS and FSR
module ram_file_responder #(
    parameter int          GPR_BANKS    = 3,
    parameter logic [7:0]  STATUS_RESET = 8'h18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] file_addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       alu_flag_we,
    input  logic       alu_z,
    input  logic       alu_dc,
    input  logic       alu_c,
    output logic [7:0] status,
    output logic [1:0] status_rp,
    output logic       status_irp,
    output logic [7:0] fsr
);

    localparam int GPR_BYTES = GPR_BANKS * 80;

    logic [1:0] bank;
    logic [6:0] off;
    logic [8:0] gpr_idx;
    logic       gpr_hit;
    logic       shared_hit;
    logic       status_hit;
    logic       fsr_hit;

    logic [7:0] gpr_q    [0:GPR_BYTES-1];
    logic [7:0] shared_q [0:15];

    logic [7:0] status_q, status_d;
    logic [7:0] fsr_q, fsr_d;
    logic [7:0] rd_mux;
    logic       pend_valid_q;
    logic [7:0] pend_data_q;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;

    assign bank       = file_addr[8:7];
    assign off        = file_addr[6:0];
    assign status_hit = (off == 7'h03);
    assign fsr_hit    = (off == 7'h04);
    assign shared_hit = (off[6:4] == 3'b111);
    assign gpr_hit    = (off >= 7'h20) && (off < 7'h70) && ({30'd0, bank} < GPR_BANKS);
    // Banks are packed back to back, 80 bytes each, starting at offset 0x20.
    assign gpr_idx    = {7'd0, bank} * 9'd80 + {2'd0, off} - 9'd32;

    always_comb begin
        rd_mux = 8'h00;
        if (status_hit)
            rd_mux = status_q;
        else if (fsr_hit)
            rd_mux = fsr_q;
        else if (shared_hit)
            rd_mux = shared_q[off[3:0]];
        else if (gpr_hit)
            rd_mux = gpr_q[gpr_idx];
    end

    // TO/PD are read-only; ALU flags override written Z/DC/C in the same cycle.
    always_comb begin
        status_d = status_q;
        fsr_d    = fsr_q;
        if (wr_en && status_hit)
            status_d = {wr_data[7:5], status_q[4:3], wr_data[2:0]};
        if (alu_flag_we)
            status_d[2:0] = {alu_z, alu_dc, alu_c};
        if (wr_en && fsr_hit)
            fsr_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en && gpr_hit)
            gpr_q[gpr_idx] <= wr_data;
        if (wr_en && shared_hit)
            shared_q[off[3:0]] <= wr_data;
    end

    // Read data is captured at the request edge so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q     <= STATUS_RESET;
            fsr_q        <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            status_q     <= status_d;
            fsr_q        <= fsr_d;
            pend_valid_q <= rd_en;
            if (rd_en)
                pend_data_q <= rd_mux;
            rd_valid_q   <= pend_valid_q;
            if (pend_valid_q)
                rd_data_q <= pend_data_q;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign status     = status_q;
    assign status_rp  = status_q[6:5];
    assign status_irp = status_q[7];
    assign fsr        = fsr_q;

endmodule

// File: tb/tb_ram_file_responder.sv
// tb/tb_ram_file_responder.sv - scoreboard bench for ram_file_responder
module tb_ram_file_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] file_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       alu_flag_we;
    logic       alu_z, alu_dc, alu_c;
    logic [7:0] status;
    logic [1:0] status_rp;
    logic       status_irp;
    logic [7:0] fsr;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;

    ram_file_responder #(.GPR_BANKS(3), .STATUS_RESET(8'h18)) dut (
        .clk(clk), .rst_n(rst_n), .file_addr(file_addr), .wr_en(wr_en),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .alu_flag_we(alu_flag_we), .alu_z(alu_z), .alu_dc(alu_dc), .alu_c(alu_c),
        .status(status), .status_rp(status_rp), .status_irp(status_irp), .fsr(fsr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", {24'd0, rd_data}, {24'd0, mon_e.data});
                check("rd_latency", cyc_cnt - mon_e.cyc, 32'd2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [7:0] d);
        file_addr = a; wr_data = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a, input logic [7:0] exp);
        file_addr = a; rd_en = 1'b1;
        sb.push_back('{data: exp, cyc: cyc_cnt});
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_rw(input logic [8:0] a, input logic [7:0] d, input logic [7:0] exp);
        file_addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b1;
        sb.push_back('{data: exp, cyc: cyc_cnt});
        step();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        step();
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; file_addr = '0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        alu_flag_we = 1'b0; alu_z = 1'b0; alu_dc = 1'b0; alu_c = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_status", status, 8'h18);
        check("rst_fsr", fsr, 8'h00);
        check("rst_rp", status_rp, 2'b00);
        check("rst_irp", status_irp, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);

        // bank separation, including the unimplemented bank 3
        do_write(9'h020, 8'h5A);
        do_write(9'h0A0, 8'h11);
        do_read(9'h020, 8'h5A);
        step();
        do_read(9'h0A0, 8'h11);
        do_read(9'h1A0, 8'h00);
        drain();

        // one GPR cell per bank, read back-to-back
        for (int b = 0; b < 4; b++) do_write({b[1:0], 7'h45}, 8'h40 + 8'(b));
        for (int b = 0; b < 4; b++) do_read({b[1:0], 7'h45}, (b < 3) ? 8'h40 + 8'(b) : 8'h00);
        drain();

        // shared region: write via one bank, read via another
        for (int i = 0; i < 16; i++) do_write({2'(i), 3'b111, 4'(i)}, 8'hC0 + 8'(i));
        for (int i = 0; i < 16; i++) do_read({2'(i + 1), 3'b111, 4'(i)}, 8'hC0 + 8'(i));
        drain();
        do_write(9'h1F5, 8'h33);
        do_read(9'h075, 8'h33);
        do_read(9'h0F5, 8'h33);
        do_read(9'h175, 8'h33);
        do_read(9'h001, 8'h00);
        drain();

        // STATUS
        do_write(9'h083, 8'h60);
        check("status_w1", status, 8'h78);
        check("status_rp_w1", status_rp, 2'b11);
        alu_flag_we = 1'b1; alu_z = 1'b0; alu_dc = 1'b0; alu_c = 1'b1;
        do_write(9'h003, 8'h07);
        alu_flag_we = 1'b0;
        check("status_w2", status, 8'h19);
        alu_flag_we = 1'b1; alu_z = 1'b1; alu_dc = 1'b0; alu_c = 1'b1;
        step();
        alu_flag_we = 1'b0;
        check("status_alu", status, 8'h1D);
        do_read(9'h183, 8'h1D);
        drain();

        // FSR and INDF
        do_write(9'h104, 8'h84);
        check("fsr_w", fsr, 8'h84);
        do_read(9'h004, 8'h84);
        do_write(9'h000, 8'hAA);
        do_read(9'h080, 8'h00);
        do_read(9'h020, 8'h5A);
        do_read(9'h0A0, 8'h11);
        do_read(9'h075, 8'h33);
        drain();
        check("fsr_after_indf", fsr, 8'h84);
        check("status_after_indf", status, 8'h1D);

        // same-cycle read/write hazard
        do_write(9'h030, 8'h5A);
        do_rw(9'h030, 8'h22, 8'h5A);
        do_read(9'h030, 8'h22);
        drain();

        // reset one cycle after rd_en: request must vanish
        file_addr = 9'h020; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        rst_n = 1'b0;
        step();
        check("midrst_rd_valid", rd_valid, 1'b0);
        check("midrst_rd_data", rd_data, 8'h00);
        check("midrst_status", status, 8'h18);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("postrst_rd_valid", rd_valid, 1'b0);
        check("postrst_rd_data", rd_data, 8'h00);
        check("postrst_fsr", fsr, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
